// File: rtl/fetch_entry_queue.sv
// -----------------------------------------------------------------------------
// fetch_entry_queue
// Instruction buffer between the frontend and the decode stage. Frontend
// entries are accepted under a valid/ready handshake, held in a DEPTH-entry
// circular FIFO and presented oldest-first to the decode stage. A flush
// discards every buffered entry in a single cycle. Entries are opaque to the
// queue: no field is ever inspected or modified.
// -----------------------------------------------------------------------------

package ariane_pkg;

  localparam int unsigned VLEN = 64;
  localparam int unsigned XLEN = 64;

  typedef enum logic [2:0] {
    NoCF   = 3'd0,
    Branch = 3'd1,
    Jump   = 3'd2,
    JumpR  = 3'd3,
    Return = 3'd4
  } cf_t;

  typedef struct packed {
    cf_t             cf;
    logic [VLEN-1:0] predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [VLEN-1:0]    address;
    logic [31:0]        instruction;
    branchpredict_sbe_t branch_predict;
    exception_t         ex;
  } fetch_entry_t;

endpackage

module fetch_entry_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter bit          FALL_THROUGH = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  fetch_entry_t               fetch_entry_i,
  input  logic                       fetch_entry_valid_i,
  output logic                       fetch_entry_ready_o,
  output fetch_entry_t               fetch_entry_o,
  output logic                       fetch_entry_valid_o,
  input  logic                       fetch_entry_ready_i,
  output logic [$clog2(DEPTH):0]     usage_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Pointers wrap through natural overflow; DEPTH is a power of two.
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  // Storage is deliberately left out of reset: the count alone decides
  // which slots hold live entries.
  fetch_entry_t mem_q [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic bypass;
  logic write_en;

  // Occupancy flags decoded from the count only (never from pointer equality).
  always_comb begin
    full    = (cnt_q == CNT_W'(DEPTH));
    empty   = (cnt_q == {CNT_W{1'b0}});
    usage_o = cnt_q;
    full_o  = full;
    empty_o = empty;
  end

  // Handshakes and output data; ready_o is independent of the consumer's ready.
  always_comb begin
    fetch_entry_ready_o = !full && !flush_i;
    fetch_entry_o       = mem_q[rd_ptr_q];
    if (FALL_THROUGH && empty) begin
      fetch_entry_valid_o = fetch_entry_valid_i && !flush_i;
      fetch_entry_o       = fetch_entry_i;
    end else begin
      fetch_entry_valid_o = !empty && !flush_i;
    end
  end

  // Transfer qualifiers; an entry that falls straight through is never stored.
  always_comb begin
    push     = fetch_entry_valid_i && fetch_entry_ready_o;
    pop      = fetch_entry_valid_o && fetch_entry_ready_i;
    bypass   = FALL_THROUGH && empty && push && pop;
    write_en = push && !bypass;
  end

  // Next-state for pointers and count; flush wins over any handshake.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      cnt_d    = {CNT_W{1'b0}};
    end else begin
      case ({push, pop})
        2'b10: begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          cnt_d    = cnt_q + CNT_W'(1);
        end
        2'b01: begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          cnt_d    = cnt_q - CNT_W'(1);
        end
        2'b11: begin
          if (bypass) begin
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
        default: begin
          rd_ptr_d = rd_ptr_q;
          wr_ptr_d = wr_ptr_q;
          cnt_d    = cnt_q;
        end
      endcase
    end
  end

  // Pointer and count registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage write; contents survive flush and reset untouched.
  always_ff @(posedge clk_i) begin
    if (write_en) begin
      mem_q[wr_ptr_q] <= fetch_entry_i;
    end
  end

endmodule

// File: tb/tb_fetch_entry_queue.sv
// -----------------------------------------------------------------------------
// Bench for fetch_entry_queue: one instance without and one with
// fall-through, driven by the same stimulus and each compared against its
// own queue-based reference model.
// -----------------------------------------------------------------------------
module tb_fetch_entry_queue;
  import ariane_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned UW    = $clog2(DEPTH) + 1;

  logic         clk;
  logic         rst_n;
  logic         flush_i;
  fetch_entry_t entry_i;
  logic         valid_i;
  logic         ready_i;

  logic         rdy_0, vld_0, full_0, empty_0;
  fetch_entry_t ent_0;
  logic [UW-1:0] use_0;
  logic         rdy_1, vld_1, full_1, empty_1;
  fetch_entry_t ent_1;
  logic [UW-1:0] use_1;

  fetch_entry_t q0[$];
  fetch_entry_t q1[$];

  int n_cmp;
  int n_err;

  fetch_entry_queue #(.DEPTH(DEPTH), .FALL_THROUGH(1'b0)) u_dut_nft (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .flush_i             (flush_i),
    .fetch_entry_i       (entry_i),
    .fetch_entry_valid_i (valid_i),
    .fetch_entry_ready_o (rdy_0),
    .fetch_entry_o       (ent_0),
    .fetch_entry_valid_o (vld_0),
    .fetch_entry_ready_i (ready_i),
    .usage_o             (use_0),
    .full_o              (full_0),
    .empty_o             (empty_0)
  );

  fetch_entry_queue #(.DEPTH(DEPTH), .FALL_THROUGH(1'b1)) u_dut_ft (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .flush_i             (flush_i),
    .fetch_entry_i       (entry_i),
    .fetch_entry_valid_i (valid_i),
    .fetch_entry_ready_o (rdy_1),
    .fetch_entry_o       (ent_1),
    .fetch_entry_valid_o (vld_1),
    .fetch_entry_ready_i (ready_i),
    .usage_o             (use_1),
    .full_o              (full_1),
    .empty_o             (empty_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic fetch_entry_t rand_entry(input logic [63:0] addr);
    logic [$bits(fetch_entry_t)-1:0] v;
    fetch_entry_t e;
    for (int i = 0; i < $bits(fetch_entry_t); i++) v[i] = 1'($urandom_range(0, 1));
    e = v;
    e.address = addr;
    return e;
  endfunction

  // Expected outputs derived from queue occupancy and current inputs.
  task automatic check_outputs(input string name, input bit ft, input int size,
                               input fetch_entry_t head, input logic rdy,
                               input logic vld, input logic [UW-1:0] usage,
                               input logic full, input logic empty,
                               input fetch_entry_t ent);
    logic exp_vld;
    fetch_entry_t exp_ent;
    exp_vld = !flush_i && (size > 0 || (ft && valid_i));
    exp_ent = (size > 0) ? head : entry_i;
    check_eq({name, ".ready_o"}, 320'(rdy), 320'(!flush_i && size < DEPTH));
    check_eq({name, ".valid_o"}, 320'(vld), 320'(exp_vld));
    check_eq({name, ".usage_o"}, 320'(usage), 320'(size));
    check_eq({name, ".full_o"}, 320'(full), 320'(size == DEPTH));
    check_eq({name, ".empty_o"}, 320'(empty), 320'(size == 0));
    if (exp_vld) check_eq({name, ".entry_o"}, 320'(ent), 320'(exp_ent));
  endtask

  // Apply one clock edge's worth of handshake rules to both models.
  task automatic update_models();
    for (int m = 0; m < 2; m++) begin
      int s;
      bit ft, rdy, vld, push, pop;
      ft  = (m == 1);
      s   = ft ? q1.size() : q0.size();
      rdy = !flush_i && s < DEPTH;
      vld = !flush_i && (s > 0 || (ft && valid_i));
      push = valid_i && rdy;
      pop  = vld && ready_i;
      if (flush_i) begin
        if (ft) q1.delete(); else q0.delete();
      end else if (!(ft && s == 0 && push && pop)) begin
        if (pop) begin
          if (ft) void'(q1.pop_front()); else void'(q0.pop_front());
        end
        if (push) begin
          if (ft) q1.push_back(entry_i); else q0.push_back(entry_i);
        end
      end
    end
  endtask

  task automatic check_both();
    check_outputs("nft", 1'b0, q0.size(), (q0.size() > 0) ? q0[0] : fetch_entry_t'('0),
                  rdy_0, vld_0, use_0, full_0, empty_0, ent_0);
    check_outputs("ft", 1'b1, q1.size(), (q1.size() > 0) ? q1[0] : fetch_entry_t'('0),
                  rdy_1, vld_1, use_1, full_1, empty_1, ent_1);
  endtask

  task automatic step(input bit fl, input bit vi, input fetch_entry_t e, input bit ri);
    @(negedge clk);
    flush_i = fl;
    valid_i = vi;
    entry_i = e;
    ready_i = ri;
    #2;
    check_both();
    @(posedge clk);
    update_models();
  endtask

  initial begin
    fetch_entry_t e;
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    entry_i = '0;
    #12;
    check_both();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full, then a refused fifth push.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rand_entry(64'h8000_0000 + 64'(4 * i)), 1'b0);
    step(1'b0, 1'b1, rand_entry(64'h8000_00F0), 1'b0);

    // Drain with wrap: push on full with pop is refused, later pushes land.
    step(1'b0, 1'b1, rand_entry(64'h8000_0010), 1'b1);
    step(1'b0, 1'b1, rand_entry(64'h8000_0010), 1'b1);
    step(1'b0, 1'b1, rand_entry(64'h8000_0014), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, rand_entry(64'h0), 1'b1);

    // Simultaneous push and pop at usage 2.
    step(1'b0, 1'b1, rand_entry(64'h8000_0100), 1'b0);
    step(1'b0, 1'b1, rand_entry(64'h8000_0104), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rand_entry(64'h8000_0108 + 64'(4 * i)), 1'b1);

    // Flush at usage 3 with both handshakes requested.
    step(1'b0, 1'b1, rand_entry(64'h8000_0200), 1'b0);
    step(1'b1, 1'b1, rand_entry(64'h8000_0204), 1'b1);
    step(1'b0, 1'b0, rand_entry(64'h0), 1'b0);

    // Fall-through on empty, consumed and then stored.
    step(1'b0, 1'b1, rand_entry(64'h1000), 1'b1);
    step(1'b0, 1'b1, rand_entry(64'h1000), 1'b0);
    step(1'b0, 1'b1, rand_entry(64'h1004), 1'b0);
    step(1'b0, 1'b0, rand_entry(64'h0), 1'b0);

    // Asynchronous reset between edges at usage 3.
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b0;
    #1;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    check_eq("async_rst.usage_nft", 320'(use_0), 320'(0));
    check_eq("async_rst.valid_nft", 320'(vld_0), 320'(0));
    check_eq("async_rst.empty_nft", 320'(empty_0), 320'(1));
    check_eq("async_rst.usage_ft", 320'(use_1), 320'(0));
    @(negedge clk);
    rst_n = 1'b1;
    e = rand_entry(64'h8000_0300);
    e.ex.valid = 1'b1;
    step(1'b0, 1'b1, e, 1'b0);
    step(1'b0, 1'b0, rand_entry(64'h0), 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
           rand_entry({32'h0, $urandom}), ($urandom_range(0, 3) != 0) ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_entry_queue.md
# fetch_entry_queue

Instruction buffer between the frontend and `id_stage`. Accepts `ariane_pkg::fetch_entry_t` entries from the frontend under a valid/ready handshake and stores them in a DEPTH-entry circular FIFO. Presents the oldest entry to `id_stage` on a matching valid/ready interface and decouples frontend stalls from decode/issue back-pressure. A flush discards all buffered entries in one cycle.

## Interface
- `DEPTH`, 4, number of entries; power of two, >= 2.
- `FALL_THROUGH`, 1'b0, 1 = when empty, an incoming entry is presented combinationally on the output in the same cycle.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; one clock, asynchronous, active-low.
- `flush_i`  in  1  discard all stored entries; block push and pop this cycle.
- `fetch_entry_i`  in  `fetch_entry_t`  entry from the frontend.
- `fetch_entry_valid_i`  in  1  frontend entry valid.
- `fetch_entry_ready_o`  out  1  queue accepts the frontend entry this cycle.
- `fetch_entry_o`  out  `fetch_entry_t`  oldest entry, to `id_stage`.
- `fetch_entry_valid_o`  out  1  `fetch_entry_o` valid.
- `fetch_entry_ready_i`  in  1  `id_stage` consumes the entry (its `fetch_entry_ready_o`).
- `usage_o`  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- `full_o`  out  1  usage == DEPTH.
- `empty_o`  out  1  usage == 0.

## Operation
- Storage: DEPTH × `fetch_entry_t` array, with a read pointer and a write pointer of $clog2(DEPTH) bits each, and a count of $clog2(DEPTH)+1 bits.
- The pointers wrap modulo DEPTH through natural overflow. Full and empty are derived from the count, never from pointer equality.
- push = `fetch_entry_valid_i` && `fetch_entry_ready_o`. pop = `fetch_entry_valid_o` && `fetch_entry_ready_i`.
- `fetch_entry_ready_o` = !full_o && !flush_i. It does not depend on `fetch_entry_ready_i`, so push on full is refused even if a pop happens in the same cycle.
- `fetch_entry_valid_o` = !empty_o && !flush_i, with one addition: when FALL_THROUGH = 1, empty and `fetch_entry_valid_i` && !flush_i also drive it high.
- `fetch_entry_o`:
  - array[read pointer] when not empty.
  - `fetch_entry_i` when FALL_THROUGH = 1 and empty.
  - Otherwise don't-care; drive the array head.
- Fall-through consumed: when FALL_THROUGH = 1, the queue is empty, and push and pop occur together, nothing is written and the pointers and count are unchanged.
- Normal push writes array[write pointer] and increments the write pointer. Normal pop increments the read pointer.
- Count update: push only → count+1; pop only → count−1; push and pop together (non-fall-through case) → count unchanged, both pointers advance.
- Flush:
  - Within the flush cycle, `fetch_entry_ready_o` = 0 and `fetch_entry_valid_o` = 0.
  - At the edge: read pointer, write pointer and count all become 0.
  - The array contents are not cleared.
- Entries pass through untouched. This includes the `ex`, `branch_predict` and `address` fields. The queue never inspects or modifies an entry.
- `full_o` and `empty_o` are decoded from the count and `usage_o` = count, all combinationally. `flush_i` does not gate these three outputs.

## Timing
- Reset (asynchronous assert) sets pointers = 0 and count = 0. Resulting outputs:
  - `usage_o` = 0, `empty_o` = 1, `full_o` = 0.
  - `fetch_entry_ready_o` = 1.
  - `fetch_entry_valid_o` = 0 (FALL_THROUGH = 1 exception: it equals `fetch_entry_valid_i` once reset is released).
  - The array is not reset.
- Reset asserted mid-operation drops every entry immediately and asynchronously. No partial write survives.
- Latency with FALL_THROUGH = 0: an entry pushed at edge N appears on `fetch_entry_o` in cycle N+1.
- Latency with FALL_THROUGH = 1: 0 cycles when the queue is empty; otherwise FIFO order applies.
- Throughput is one push and one pop per cycle. Sustained full rate is possible at any usage between 1 and DEPTH−1.
- Order is strict FIFO, including across pointer wrap-around.
- Flush combined with push and pop in the same cycle: flush wins. Neither handshake completes and the queue is empty next cycle.
- No combinational path from `fetch_entry_ready_i` to `fetch_entry_ready_o`.

## Test plan
- Reset then fill, DEPTH = 4, FALL_THROUGH = 0, `fetch_entry_ready_i` = 0:
  - Push addresses 0x80000000, 0x80000004, 0x80000008, 0x8000000C.
  - Required: `usage_o` steps 1, 2, 3, 4; `full_o` = 1 and `fetch_entry_ready_o` = 0 after the 4th edge.
  - A 5th `fetch_entry_valid_i` is not accepted.
- Drain and wrap:
  - From full, raise `fetch_entry_ready_i` while pushing 0x80000010 and 0x80000014 as space frees.
  - Required: outputs appear in order 0x80000000 … 0x80000014 with no loss or duplication across the pointer wrap; `empty_o` = 1 after the last pop.
- Simultaneous push and pop at usage 2:
  - Required: `usage_o` stays 2 and both pointers advance.
  - Push on full with a concurrent pop is refused: usage 4 → 3.
- Flush with usage 3, valid_i = 1 and ready_i = 1 in the flush cycle:
  - Required: valid_o = 0 and ready_o = 0 in that cycle; next cycle `usage_o` = 0, `empty_o` = 1, and no stale entry is presented.
- FALL_THROUGH = 1, empty queue, valid_i = 1 with address 0x1000 and ready_i = 1:
  - Required: valid_o = 1 and `fetch_entry_o`.address = 0x1000 in the same cycle; `usage_o` stays 0.
  - With ready_i = 0 instead: entry stored, `usage_o` = 1.
- Asynchronous reset mid-stream with usage 3:
  - Assert `rst_ni` = 0 between edges.
  - Required: `usage_o` = 0, valid_o = 0 and `empty_o` = 1 immediately, without waiting for an edge.
  - An entry carrying `ex`.valid = 1 pushed afterwards emerges with `ex` unchanged.
